serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter N: default 4; operand width in bits, legal range N >= 2.
REQ-002 SHALL derive localparam CW = $clog2(N+1) for the bit counter; CW SHALL NOT be overridable.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request a new subtraction; sampled only in IDLE or DONE.
REQ-006 SHALL have port a, input, N bits: minuend, unsigned; sampled only on an accepted start.
REQ-007 SHALL have port b, input, N bits: subtrahend, unsigned; sampled only on an accepted start.
REQ-008 SHALL have port busy, output, 1 bit: high while the subtraction is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when diff and bout become valid.
REQ-010 SHALL have port diff, output, N bits: (a - b) mod 2^N.
REQ-011 SHALL have port bout, output, 1 bit: borrow out; 1 iff a < b unsigned.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE -> SHIFT on an edge with start=1: latch a and b into shift registers, clear borrow, load counter = N, drive busy=1 from the next cycle.
REQ-014 SHALL process in SHIFT exactly one bit per clock, LSB first: d = ai XOR bi XOR br; br_next = (~ai & bi) | (~(ai XOR bi) & br).
REQ-015 SHALL shift each d into the diff register from the MSB end, so bit i of the result lands at diff[i] after N shifts.
REQ-016 SHALL decrement the counter once per SHIFT cycle; on the edge that processes the last bit (counter = 1): go to DONE, set busy=0, done=1, bout = final borrow.
REQ-017 Latency: start accepted on edge k -> busy high for cycles k+1..k+N; done high for exactly the one cycle after edge k+N.
REQ-018 DONE -> IDLE on the next edge unconditionally; done=0 in that cycle.
REQ-019 start=1 in DONE SHALL be accepted exactly as in IDLE, giving back-to-back operations with no idle gap.
REQ-020 start in SHIFT SHALL be ignored; a and b changes in SHIFT SHALL NOT affect the running result.
REQ-021 SHALL hold diff and bout stable from the done cycle until the next accepted start.
REQ-022 diff and bout SHALL NOT be valid while busy=1; their values during SHIFT are unspecified.
REQ-023 SHALL produce the correct result for the boundary cases a=b, a=0, b=0, and a=2^N-1, b=2^N-1.

Reset
REQ-024 reset=1 at any edge SHALL force IDLE and clear busy, done, diff, bout, borrow, counter and the operand registers to 0; reset takes priority over start.
REQ-025 reset mid-SHIFT SHALL abort the operation with no done pulse; the first start after reset is deasserted SHALL be accepted normally.

Verification
REQ-026 N=4, a=0011, b=0001, start 1 cycle -> done exactly 4 cycles after acceptance; diff=0010, bout=0.
REQ-027 a=0001, b=0010 -> diff=1111, bout=1; a=0000, b=0001 -> diff=1111, bout=1.
REQ-028 a=1111, b=1111 -> diff=0000, bout=0; a=0000, b=0000 -> diff=0000, bout=0.
REQ-029 Apply start with a=1010, b=0101; pulse start with a=0000, b=1111 in cycle 2 of SHIFT -> second request ignored; result diff=0101, bout=0; only one done pulse.
REQ-030 Assert reset in cycle 2 of SHIFT -> next cycle busy=0, done=0, diff=0000, bout=0; no done pulse; a following start with a=0110, b=0011 -> diff=0011, bout=0.
REQ-031 Hold start=1 through DONE with new operands a=0100, b=0101 -> second operation starts with no idle cycle; diff=1111, bout=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, LSB first, one bit per clock
module serial_subtractor #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] a_sh, b_sh;
  logic [CW-1:0] cnt;
  logic br, br_nx, d, ld, last;
  always_comb begin
    ld = start && state != SHIFT;
    last = state == SHIFT && cnt == CW'(1);
    d = a_sh[0] ^ b_sh[0] ^ br;
    br_nx = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    state_nx = ld ? SHIFT : last ? DONE : state == DONE ? IDLE : state;
    busy = state == SHIFT;
    done = state == DONE;
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
      br   <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
    end else if (ld) begin
      a_sh <= a;
      b_sh <= b;
      cnt  <= CW'(N);
      br   <= 1'b0;
    end else if (state == SHIFT) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt - 1'b1;
      br   <= br_nx;
      diff <= {d, diff[N-1:1]};
      if (last) bout <= br_nx;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of the serial subtractor at N=4
module tb_serial_subtractor;
  logic clk = 0, reset = 1, start = 0;
  logic [3:0] a = 0, b = 0;
  logic busy, done, bout;
  logic [3:0] diff;
  int n_chk = 0, n_fail = 0;

  serial_subtractor #(.N(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic op(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] ed,
                    input logic eb, input string tag);
    int cyc;
    @(negedge clk);
    start = 1; a = ta; b = tb;
    @(negedge clk);
    start = 0; a = ~ta; b = ~tb;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_nodone"}, done, 0);
    wait_done(cyc);
    check({tag, "_lat"}, cyc, 4);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_idle"}, busy, 0);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
    check({tag, "_hold"}, diff, ed);
    check({tag, "_holdb"}, bout, eb);
  endtask

  initial begin
    int cyc, pulses;
    repeat (2) @(negedge clk);
    reset = 1; start = 1; a = 4'hf; b = 4'h1;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    reset = 0; start = 0;

    op(4'b0011, 4'b0001, 4'b0010, 0, "r26");
    op(4'b0001, 4'b0010, 4'b1111, 1, "r27a");
    op(4'b0000, 4'b0001, 4'b1111, 1, "r27b");
    op(4'b1111, 4'b1111, 4'b0000, 0, "r28a");
    op(4'b0000, 4'b0000, 4'b0000, 0, "r28b");
    op(4'b1001, 4'b0000, 4'b1001, 0, "bzero");
    op(4'b0110, 4'b0110, 4'b0000, 0, "aeqb");

    // start mid-SHIFT must be ignored
    @(negedge clk);
    start = 1; a = 4'b1010; b = 4'b0101;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1; a = 4'b0000; b = 4'b1111;
    @(negedge clk);
    start = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) begin
        pulses++;
        check("r29_diff", diff, 4'b0101);
        check("r29_bout", bout, 0);
      end
      @(negedge clk);
    end
    check("r29_pulses", pulses, 1);

    // reset in cycle 2 of SHIFT aborts
    start = 1; a = 4'b1100; b = 4'b0001;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("r30_busy", busy, 0);
    check("r30_done", done, 0);
    check("r30_diff", diff, 0);
    check("r30_bout", bout, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    check("r30_nopulse", pulses, 0);
    op(4'b0110, 4'b0011, 4'b0011, 0, "r30");

    // start held through DONE gives back-to-back operation
    @(negedge clk);
    start = 1; a = 4'b0011; b = 4'b0001;
    @(negedge clk);
    a = 4'b0100; b = 4'b0101;
    wait_done(cyc);
    check("r31_lat1", cyc, 4);
    check("r31_diff1", diff, 4'b0010);
    check("r31_bout1", bout, 0);
    @(negedge clk);
    start = 0;
    check("r31_nogap", busy, 1);
    check("r31_nodone", done, 0);
    wait_done(cyc);
    check("r31_lat2", cyc, 4);
    check("r31_diff2", diff, 4'b1111);
    check("r31_bout2", bout, 1);
    @(negedge clk);
    check("r31_idle", busy | done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
